// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_pkg
//  Description : Shared defaults and FSM state encoding for the sequential
//                vector doubler (mul_by2_vec_seq).
//                  IWIDTH_DEF  - default element width in bits
//                  NINPUTS_DEF - default number of elements per vector
//                  state_t     - controller states IDLE / CALC / DONE
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    localparam int IWIDTH_DEF  = 10;
    localparam int NINPUTS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/mul_by2_sat.sv
`default_nettype none
// ============================================================================
//  Module      : mul_by2_sat
//  Description : Combinational saturating doubler for one unsigned element.
//                When the MSB is set, doubling would overflow, so the result
//                clamps to all ones and the saturation flag is raised.
//  Ports       : din  [IWIDTH-1:0] in  - element to double
//                dout [IWIDTH-1:0] out - doubled / saturated element
//                sat               out - 1 when dout was clamped
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_by2_sat #(
    parameter int IWIDTH = 10
) (
    input  logic [IWIDTH-1:0] din,
    output logic [IWIDTH-1:0] dout,
    output logic              sat
);

    always_comb begin
        sat  = din[IWIDTH-1];
        dout = din << 1;
        if (din[IWIDTH-1]) begin
            dout = '1;
        end
    end

endmodule : mul_by2_sat
`default_nettype wire

// File: rtl/mul_by2_vec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_by2_vec_seq
//  Description : Sequential saturating vector doubler. A vector is captured
//                on the input handshake, then one element per cycle is
//                doubled through a single shared mul_by2_sat instance and
//                written into the output register. The finished vector is
//                presented with out_valid until the consumer accepts it.
//  Ports       : clk        in  - clock, rising edge
//                rst        in  - synchronous active-high reset
//                in_valid   in  - input vector valid
//                in_ready   out - block can accept a vector (IDLE only)
//                data       in  - input vector [NINPUTS-1:0] x IWIDTH
//                out_valid  out - result vector valid (DONE only)
//                out_ready  in  - consumer accepts result
//                out        out - doubled vector [NINPUTS-1:0] x IWIDTH
//                sat        out - per-element saturation flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_by2_vec_seq
    import vec_pkg::*;
#(
    parameter int IWIDTH  = IWIDTH_DEF,
    parameter int NINPUTS = NINPUTS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IWIDTH-1:0]   data [NINPUTS-1:0],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IWIDTH-1:0]   out  [NINPUTS-1:0],
    output logic [NINPUTS-1:0]  sat
);

    localparam int                IDX_W      = $clog2(NINPUTS);
    localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(NINPUTS - 1);
    localparam logic [IDX_W-1:0]  C_IDX_ONE  = IDX_W'(1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [IWIDTH-1:0]    data_q   [NINPUTS-1:0];
    logic [IWIDTH-1:0]    data_d   [NINPUTS-1:0];
    logic [IWIDTH-1:0]    out_q    [NINPUTS-1:0];
    logic [IWIDTH-1:0]    out_d    [NINPUTS-1:0];
    logic [NINPUTS-1:0]   sat_q,   sat_d;

    logic [IWIDTH-1:0]    w_elem;
    logic [IWIDTH-1:0]    w_dout;
    logic                 w_sat;

    // Single shared doubler; the captured element is selected by idx.
    assign w_elem = data_q[idx_q];

    mul_by2_sat #(
        .IWIDTH (IWIDTH)
    ) u_mul_by2_sat (
        .din  (w_elem),
        .dout (w_dout),
        .sat  (w_sat)
    );

    // Handshake signals depend only on state (and reset), never on the
    // opposite handshake input, so no combinational loop can form.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE) && !rst;
    assign out       = out_q;
    assign sat       = sat_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        out_d   = out_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end

            CALC: begin
                out_d[idx_q] = w_dout;
                sat_d[idx_q] = w_sat;
                // Stop at the last element rather than wrapping the index.
                if (idx_q == C_IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + C_IDX_ONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '{default: '0};
            out_q   <= '{default: '0};
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

endmodule : mul_by2_vec_seq
`default_nettype wire

// File: tb/tb_mul_by2_vec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_by2_vec_seq
//  Description : Directed self-checking bench for mul_by2_vec_seq
//                (IWIDTH=10, NINPUTS=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_by2_vec_seq;

    localparam int IW = 10;
    localparam int NI = 8;

    typedef logic [IW-1:0] vec_t [NI-1:0];

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    vec_t           data;
    vec_t           out_w;
    logic [NI-1:0]  sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_by2_vec_seq #(
        .IWIDTH  (IW),
        .NINPUTS (NI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_w),
        .sat       (sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one vector through the handshake and returns the number of
    // cycles from the handshake edge until out_valid (30 = timed out).
    task automatic send_vec(input vec_t v, output int lat);
        int n;
        n        = 0;
        data     = v;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        data      = '{default: 10'd5};
        step();
        step();
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (sat !== 8'h00) begin
            bad++; $display("FAIL reset_sat: got %h want 00", sat);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (out_w[i] !== 10'd0) begin
                bad++; $display("FAIL reset_out[%0d]: got %0d want 0", i, out_w[i]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        vec_t v   = '{10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0};
        vec_t exp = '{10'd14, 10'd12, 10'd10, 10'd8, 10'd6, 10'd4, 10'd2, 10'd0};
        int lat;
        out_ready = 1'b1;
        send_vec(v, lat);
        total++;
        if (lat !== 8) begin
            bad++; $display("FAIL basic_latency: got %0d want 8", lat);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (out_w[i] !== exp[i]) begin
                bad++; $display("FAIL basic_out[%0d]: got %0d want %0d", i, out_w[i], exp[i]);
            end
        end
        total++;
        if (sat !== 8'h00) begin
            bad++; $display("FAIL basic_sat: got %h want 00", sat);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_ov_one_cycle: got %b want 0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL basic_back_idle: got %b want 1", in_ready);
        end
        total++;
        if (out_w[7] !== 10'd14) begin
            bad++; $display("FAIL basic_retain: got %0d want 14", out_w[7]);
        end
    endtask

    task automatic test_sat();
        vec_t v   = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1023, 10'd512, 10'd511};
        vec_t exp = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1023, 10'd1023, 10'd1022};
        int lat;
        out_ready = 1'b1;
        send_vec(v, lat);
        total++;
        if (lat !== 8) begin
            bad++; $display("FAIL sat_latency: got %0d want 8", lat);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (out_w[i] !== exp[i]) begin
                bad++; $display("FAIL sat_out[%0d]: got %0d want %0d", i, out_w[i], exp[i]);
            end
        end
        total++;
        if (sat !== 8'h06) begin
            bad++; $display("FAIL sat_flags: got %h want 06", sat);
        end
        step();
    endtask

    task automatic test_stall();
        vec_t v   = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd3, 10'd600};
        int lat;
        out_ready = 1'b0;
        send_vec(v, lat);
        total++;
        if (lat !== 8) begin
            bad++; $display("FAIL stall_latency: got %0d want 8", lat);
        end
        in_valid = 1'b1;
        data     = '{default: 10'd9};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1) begin
                bad++; $display("FAIL stall_ov[%0d]: got %b want 1", k, out_valid);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready);
            end
            total++;
            if (out_w[0] !== 10'd1023 || out_w[1] !== 10'd6) begin
                bad++; $display("FAIL stall_out[%0d]: got %0d,%0d want 1023,6", k, out_w[0], out_w[1]);
            end
            total++;
            if (sat !== 8'h01) begin
                bad++; $display("FAIL stall_sat[%0d]: got %h want 01", k, sat);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        total++;
        if (out_w[1] !== 10'd6 || out_w[2] !== 10'd0) begin
            bad++; $display("FAIL stall_not_captured: got %0d,%0d want 6,0", out_w[1], out_w[2]);
        end
    endtask

    task automatic test_reset_mid();
        vec_t v8 = '{default: 10'd8};
        int lat;
        out_ready = 1'b1;
        data      = '{default: 10'd1};
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_state: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        total++;
        if (sat !== 8'h00) begin
            bad++; $display("FAIL rstmid_sat: got %h want 00", sat);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (out_w[i] !== 10'd0) begin
                bad++; $display("FAIL rstmid_out[%0d]: got %0d want 0", i, out_w[i]);
            end
        end
        send_vec(v8, lat);
        total++;
        if (lat !== 8) begin
            bad++; $display("FAIL rstmid_latency: got %0d want 8", lat);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (out_w[i] !== 10'd16) begin
                bad++; $display("FAIL rstmid_out16[%0d]: got %0d want 16", i, out_w[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        vec_t v   = '{10'd80, 10'd70, 10'd60, 10'd50, 10'd40, 10'd30, 10'd20, 10'd10};
        vec_t exp = '{10'd160, 10'd140, 10'd120, 10'd100, 10'd80, 10'd60, 10'd40, 10'd20};
        int hs1 = -1;
        int hs2 = -1;
        int ov1 = -1;
        int ov2 = -1;
        out_ready = 1'b1;
        data      = v;
        in_valid  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (in_ready === 1'b1) begin
                if (hs1 < 0) hs1 = k;
                else if (hs2 < 0) hs2 = k;
            end
            if (out_valid === 1'b1) begin
                if (ov1 < 0) begin
                    ov1 = k;
                end else begin
                    ov2      = k;
                    in_valid = 1'b0;
                    break;
                end
            end
            step();
        end
        in_valid = 1'b0;
        total++;
        if (hs1 !== 0 || ov1 !== 9) begin
            bad++; $display("FAIL b2b_first: got hs=%0d ov=%0d want hs=0 ov=9", hs1, ov1);
        end
        total++;
        if (hs2 !== ov1 + 1) begin
            bad++; $display("FAIL b2b_second_hs: got %0d want %0d", hs2, ov1 + 1);
        end
        total++;
        if (ov2 - ov1 !== 10) begin
            bad++; $display("FAIL b2b_period: got %0d want 10", ov2 - ov1);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (out_w[i] !== exp[i]) begin
                bad++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i, out_w[i], exp[i]);
            end
        end
        step();
    endtask

    task automatic test_data_change();
        vec_t v    = '{10'd12, 10'd11, 10'd10, 10'd9, 10'd8, 10'd7, 10'd6, 10'd5};
        vec_t exp  = '{10'd24, 10'd22, 10'd20, 10'd18, 10'd16, 10'd14, 10'd12, 10'd10};
        vec_t junk_a = '{default: 10'd1023};
        vec_t junk_b = '{default: 10'd100};
        int lat;
        out_ready = 1'b1;
        data      = v;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            data = lat[0] ? junk_a : junk_b;
            step();
            lat++;
        end
        total++;
        if (lat !== 8) begin
            bad++; $display("FAIL chg_latency: got %0d want 8", lat);
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (out_w[i] !== exp[i]) begin
                bad++; $display("FAIL chg_out[%0d]: got %0d want %0d", i, out_w[i], exp[i]);
            end
        end
        total++;
        if (sat !== 8'h00) begin
            bad++; $display("FAIL chg_sat: got %h want 00", sat);
        end
        step();
    endtask

    initial begin
        data = '{default: 10'd0};
        test_reset();
        test_basic();
        test_sat();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_data_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_mul_by2_vec_seq
`default_nettype wire
